// File: rtl/bg_pkg.sv
// Shared constants and types for the background-layer fetch sequencer.
package bg_pkg;

  localparam int unsigned ScreenWidth  = 800;
  localparam int unsigned ScreenHeight = 600;
  localparam int unsigned ImageWidth   = 640;
  localparam int unsigned ImageHeight  = 480;
  localparam int unsigned AddrW        = 19;
  localparam int unsigned CoordW       = 10;
  localparam int unsigned RgbW         = 24;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StIssue,
    StDrain,
    StDone
  } bg_state_e;

  typedef struct packed {
    logic [CoordW-1:0] x;
    logic [CoordW-1:0] y;
    logic [RgbW-1:0]   rgb;
  } pix_tag_t;

endpackage

// File: rtl/bg_fetch_ctrl_if.sv
// Frame control, SDRAM read port and pixel output bundle of the background fetch sequencer.
interface bg_fetch_ctrl_if;
  import bg_pkg::*;

  logic              frame_start;
  logic [CoordW-1:0] anchor_x;
  logic [CoordW-1:0] anchor_y;
  logic              mem_req;
  logic [AddrW-1:0]  mem_addr;
  logic              mem_ack;
  logic              mem_rvalid;
  logic [RgbW-1:0]   mem_rdata;
  logic              pix_valid;
  logic              pix_ready;
  logic [7:0]        r_out;
  logic [7:0]        g_out;
  logic [7:0]        b_out;
  logic [CoordW-1:0] x_out;
  logic [CoordW-1:0] y_out;
  logic              busy;
  logic              frame_done;

  modport master (
    input  frame_start, anchor_x, anchor_y, mem_ack, mem_rvalid, mem_rdata, pix_ready,
    output mem_req, mem_addr, pix_valid, r_out, g_out, b_out, x_out, y_out, busy, frame_done
  );

  modport slave (
    output frame_start, anchor_x, anchor_y, mem_ack, mem_rvalid, mem_rdata, pix_ready,
    input  mem_req, mem_addr, pix_valid, r_out, g_out, b_out, x_out, y_out, busy, frame_done
  );

endinterface

// File: rtl/bg_pix_buf.sv
// In-order pixel buffer: entries are allocated with a screen tag on request accept, filled
// with read data in request order, and popped from the head through a registered output.
module bg_pix_buf import bg_pkg::*; #(
  parameter int unsigned Depth = 4
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              alloc_i,
  input  logic [CoordW-1:0] alloc_x_i,
  input  logic [CoordW-1:0] alloc_y_i,
  input  logic              fill_i,
  input  logic [RgbW-1:0]   fill_rgb_i,
  input  logic              pop_i,
  output logic              head_valid_o,
  output pix_tag_t          head_o
);

  // Depth must be a power of two >= 2 so the wrap-bit pointers roll over cleanly.
  localparam int unsigned IdxW = $clog2(Depth);
  localparam int unsigned PtrW = IdxW + 1;

  pix_tag_t         mem_q [Depth];
  pix_tag_t         mem_d [Depth];
  logic [Depth-1:0] filled_q, filled_d;
  logic [PtrW-1:0]  alloc_q, alloc_d, fill_q, fill_d, head_q, head_d;
  logic             valid_q, valid_d;
  pix_tag_t         out_q, out_d;
  logic             fill_en;

  // Read data with no outstanding unfilled entry is dropped.
  assign fill_en = fill_i && (fill_q != alloc_q);

  always_comb begin
    mem_d    = mem_q;
    filled_d = filled_q;
    alloc_d  = alloc_q;
    fill_d   = fill_q;
    head_d   = head_q;
    if (alloc_i) begin
      mem_d[alloc_q[IdxW-1:0]].x   = alloc_x_i;
      mem_d[alloc_q[IdxW-1:0]].y   = alloc_y_i;
      mem_d[alloc_q[IdxW-1:0]].rgb = '0;
      alloc_d = alloc_q + PtrW'(1);
    end
    if (fill_en) begin
      mem_d[fill_q[IdxW-1:0]].rgb = fill_rgb_i;
      filled_d[fill_q[IdxW-1:0]]  = 1'b1;
      fill_d = fill_q + PtrW'(1);
    end
    if (pop_i) begin
      filled_d[head_q[IdxW-1:0]] = 1'b0;
      head_d = head_q + PtrW'(1);
    end
    valid_d = filled_d[head_d[IdxW-1:0]];
    out_d   = mem_d[head_d[IdxW-1:0]];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      filled_q <= '0;
      alloc_q  <= '0;
      fill_q   <= '0;
      head_q   <= '0;
      valid_q  <= 1'b0;
      out_q    <= '0;
    end else begin
      filled_q <= filled_d;
      alloc_q  <= alloc_d;
      fill_q   <= fill_d;
      head_q   <= head_d;
      valid_q  <= valid_d;
      out_q    <= out_d;
    end
  end

  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign head_valid_o = valid_q;
  assign head_o       = out_q;

endmodule

// File: rtl/bg_fetch_ctrl.sv
// Background-layer fetch sequencer: scans the image per frame, issues one SDRAM read per
// on-screen pixel and returns tagged pixels in scan order under a DEPTH-token flow control.
module bg_fetch_ctrl import bg_pkg::*; #(
  parameter int unsigned Depth = 4
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  bg_fetch_ctrl_if.master bus_io
);

  localparam int unsigned TokW = $clog2(Depth + 1);

  bg_state_e         state_q, state_d;
  logic [CoordW-1:0] ax_q, ax_d, ay_q, ay_d, col_q, col_d, row_q, row_d;
  logic [AddrW-1:0]  row_base_q, row_base_d, mem_addr_q, mem_addr_d;
  logic [TokW-1:0]   tokens_q, tokens_d;
  logic              mem_req_q, mem_req_d, busy_q, busy_d, done_q, done_d;
  logic              accept, pop, pix_valid, col_wrap, row_end, anchor_bad;
  logic [CoordW:0]   x_next, y_next;
  logic [CoordW-1:0] tag_x, tag_y;
  pix_tag_t          head;

  assign accept     = mem_req_q & bus_io.mem_ack;
  assign pop        = pix_valid & bus_io.pix_ready;
  assign tag_x      = ax_q + col_q;
  assign tag_y      = ay_q + row_q;
  assign x_next     = {1'b0, ax_q} + {1'b0, col_q} + (CoordW+1)'(1);
  assign y_next     = {1'b0, ay_q} + {1'b0, row_q} + (CoordW+1)'(1);
  assign col_wrap   = (col_q + CoordW'(1) == CoordW'(ImageWidth)) ||
                      (x_next >= (CoordW+1)'(ScreenWidth));
  assign row_end    = (row_q + CoordW'(1) == CoordW'(ImageHeight)) ||
                      (y_next >= (CoordW+1)'(ScreenHeight));
  assign anchor_bad = ({1'b0, bus_io.anchor_x} >= (CoordW+1)'(ScreenWidth)) ||
                      ({1'b0, bus_io.anchor_y} >= (CoordW+1)'(ScreenHeight));

  always_comb begin
    state_d    = state_q;
    ax_d       = ax_q;
    ay_d       = ay_q;
    col_d      = col_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    unique case (state_q)
      StIdle: begin
        if (bus_io.frame_start) state_d = StSetup;
      end
      StSetup: begin
        ax_d       = bus_io.anchor_x;
        ay_d       = bus_io.anchor_y;
        col_d      = '0;
        row_d      = '0;
        row_base_d = '0;
        state_d    = anchor_bad ? StDone : StIssue;
      end
      StIssue: begin
        if (accept) begin
          if (col_wrap) begin
            col_d      = '0;
            row_d      = row_q + CoordW'(1);
            row_base_d = row_base_q + AddrW'(ImageWidth);
            if (row_end) state_d = StDrain;
          end else begin
            col_d = col_q + CoordW'(1);
          end
        end
      end
      StDrain: begin
        if (tokens_q == '0) state_d = StDone;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Tokens cover both reads in flight and filled entries awaiting the pixel handshake.
  always_comb begin
    tokens_d = tokens_q;
    if (accept && !pop) begin
      tokens_d = tokens_q + TokW'(1);
    end else if (pop && !accept) begin
      tokens_d = tokens_q - TokW'(1);
    end
  end

  always_comb begin
    mem_req_d  = (state_d == StIssue) && (tokens_d < TokW'(Depth));
    mem_addr_d = row_base_d + AddrW'(col_d);
    busy_d     = (state_d != StIdle);
    done_d     = (state_d == StDone);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      ax_q       <= '0;
      ay_q       <= '0;
      col_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      tokens_q   <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      ax_q       <= ax_d;
      ay_q       <= ay_d;
      col_q      <= col_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      tokens_q   <= tokens_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  bg_pix_buf #(
    .Depth (Depth)
  ) u_pix_buf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .alloc_i      (accept),
    .alloc_x_i    (tag_x),
    .alloc_y_i    (tag_y),
    .fill_i       (bus_io.mem_rvalid),
    .fill_rgb_i   (bus_io.mem_rdata),
    .pop_i        (pop),
    .head_valid_o (pix_valid),
    .head_o       (head)
  );

  assign bus_io.mem_req    = mem_req_q;
  assign bus_io.mem_addr   = mem_addr_q;
  assign bus_io.pix_valid  = pix_valid;
  assign bus_io.r_out      = head.rgb[23:16];
  assign bus_io.g_out      = head.rgb[15:8];
  assign bus_io.b_out      = head.rgb[7:0];
  assign bus_io.x_out      = head.x;
  assign bus_io.y_out      = head.y;
  assign bus_io.busy       = busy_q;
  assign bus_io.frame_done = done_q;

endmodule

// File: tb/tb_bg_fetch_ctrl.sv
// Directed and randomised bench for bg_fetch_ctrl with an in-order SDRAM model and scoreboard.
module tb_bg_fetch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bg_fetch_ctrl_if bus ();

  bg_fetch_ctrl #(
    .Depth (4)
  ) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus_io (bus)
  );

  typedef struct { int x; int y; int addr; } pix_t;
  typedef struct { logic [23:0] rgb; int due; } rd_t;

  pix_t ref_q[$];
  pix_t exp_q[$];
  rd_t  pend_q[$];

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int ack_mode = 0;
  int ready_mode = 0;
  int lat_min = 1;
  int lat_max = 1;
  bit fs_req = 1'b0;
  int n_acc, n_pix, n_done, exp_cnt;
  int done_cyc, fs_cyc, last_pop_cyc, first_acc_cyc, last_acc_cyc;

  function automatic logic [23:0] rgb_of(input int addr);
    logic [31:0] a;
    logic [31:0] h;
    a = addr;
    h = a * 32'h9E37_79B1;
    return h[31:8];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, 64'({bus.mem_req, bus.busy, bus.frame_done, bus.pix_valid}), 64'(0));
    check({tag, "_addr"}, 64'(bus.mem_addr), 64'(0));
    check({tag, "_pix"}, 64'({bus.r_out, bus.g_out, bus.b_out, bus.x_out, bus.y_out}), 64'(0));
  endtask

  // One cycle: sample outputs at the falling edge, drive inputs, log upcoming handshakes.
  task automatic step();
    rd_t  rd;
    pix_t p;
    @(negedge clk);
    cyc++;
    bus.frame_start = fs_req;
    if (fs_req) fs_cyc = cyc;
    fs_req = 1'b0;
    bus.mem_ack = (ack_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
    case (ready_mode)
      0:       bus.pix_ready = 1'b1;
      1:       bus.pix_ready = 1'b0;
      default: bus.pix_ready = 1'($urandom_range(0, 1));
    endcase
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      bus.mem_rvalid = 1'b1;
      bus.mem_rdata  = pend_q[0].rgb;
      void'(pend_q.pop_front());
    end else begin
      bus.mem_rvalid = 1'b0;
      bus.mem_rdata  = 24'($urandom);
    end
    if (bus.frame_done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (bus.mem_req && bus.mem_ack) begin
      check("req_expected", 64'(ref_q.size() != 0), 64'(1));
      if (ref_q.size() != 0) begin
        p = ref_q.pop_front();
        check("mem_addr", 64'(bus.mem_addr), 64'(p.addr));
        exp_q.push_back(p);
      end
      rd.rgb = rgb_of(int'(bus.mem_addr));
      rd.due = cyc + int'($urandom_range(lat_min, lat_max));
      pend_q.push_back(rd);
      n_acc++;
      if (n_acc == 1) first_acc_cyc = cyc;
      last_acc_cyc = cyc;
    end
    if (bus.pix_valid && bus.pix_ready) begin
      check("pix_expected", 64'(exp_q.size() != 0), 64'(1));
      if (exp_q.size() != 0) begin
        p = exp_q.pop_front();
        check("pix_xy", 64'({bus.x_out, bus.y_out}), 64'({10'(p.x), 10'(p.y)}));
        check("pix_rgb", 64'({bus.r_out, bus.g_out, bus.b_out}), 64'(rgb_of(p.addr)));
      end
      n_pix++;
      last_pop_cyc = cyc;
    end
  endtask

  task automatic start_frame(input int ax, input int ay);
    ref_q.delete();
    exp_q.delete();
    n_acc = 0;
    n_pix = 0;
    n_done = 0;
    done_cyc = -1;
    last_pop_cyc = -1;
    first_acc_cyc = -1;
    last_acc_cyc = -1;
    for (int r = 0; r < 480 && ay + r < 600; r++) begin
      for (int c = 0; c < 640 && ax + c < 800; c++) begin
        ref_q.push_back('{x: ax + c, y: ay + r, addr: r * 640 + c});
      end
    end
    exp_cnt = ref_q.size();
    bus.anchor_x = 10'(ax);
    bus.anchor_y = 10'(ay);
    fs_req = 1'b1;
  endtask

  task automatic finish_frame(input int budget, input bit has_pix);
    int k;
    k = 0;
    while (n_done == 0 && k < budget) begin
      step();
      k++;
    end
    check("frame_done_seen", 64'(n_done), 64'(1));
    if (has_pix) check("done_after_last_pop", 64'(done_cyc - last_pop_cyc), 64'(2));
    else check("done_after_start", 64'(done_cyc - fs_cyc), 64'(2));
    repeat (6) step();
    check("single_frame_done", 64'(n_done), 64'(1));
    check("busy_idle", 64'(bus.busy), 64'(0));
    check("pix_count", 64'(n_pix), 64'(exp_cnt));
    check("acc_count", 64'(n_acc), 64'(exp_cnt));
    check("ref_left", 64'(ref_q.size()), 64'(0));
  endtask

  initial begin
    bus.frame_start = 1'b0;
    bus.anchor_x    = '0;
    bus.anchor_y    = '0;
    bus.mem_ack     = 1'b0;
    bus.mem_rvalid  = 1'b0;
    bus.mem_rdata   = '0;
    bus.pix_ready   = 1'b0;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) step();

    // Off-screen anchors: no requests, frame_done two cycles after frame_start.
    start_frame(800, 0);
    finish_frame(20, 1'b0);
    start_frame(0, 600);
    finish_frame(20, 1'b0);

    // Clipped corner with one request per cycle across row wraps.
    ack_mode = 0; ready_mode = 0; lat_min = 1; lat_max = 1;
    start_frame(780, 590);
    finish_frame(2000, 1'b1);
    check("first_req_latency", 64'(first_acc_cyc - fs_cyc), 64'(2));
    check("req_per_cycle", 64'(last_acc_cyc - first_acc_cyc), 64'(199));

    // 100x50 corner with fixed read latency of 3.
    lat_min = 3; lat_max = 3;
    start_frame(700, 550);
    finish_frame(30000, 1'b1);

    // Output stalled: token limit caps accepts, head held stable.
    ready_mode = 1; lat_min = 1; lat_max = 1;
    start_frame(780, 590);
    repeat (20) step();
    check("stall_accepts", 64'(n_acc), 64'(4));
    check("stall_no_req", 64'(bus.mem_req), 64'(0));
    for (int i = 0; i < 3; i++) begin
      check("stall_valid", 64'(bus.pix_valid), 64'(1));
      check("stall_xy", 64'({bus.x_out, bus.y_out}), 64'({10'(exp_q[0].x), 10'(exp_q[0].y)}));
      check("stall_rgb", 64'({bus.r_out, bus.g_out, bus.b_out}), 64'(rgb_of(exp_q[0].addr)));
      step();
    end
    ready_mode = 0;
    finish_frame(2000, 1'b1);

    // Random handshakes and latency, with a frame_start pulse while busy.
    ack_mode = 1; ready_mode = 2; lat_min = 1; lat_max = 6;
    start_frame(750, 560);
    repeat (100) step();
    bus.anchor_x = 10'd0;
    bus.anchor_y = 10'd0;
    fs_req = 1'b1;
    finish_frame(40000, 1'b1);

    // Reset with three reads in flight; their late data must be dropped.
    ack_mode = 0; ready_mode = 0; lat_min = 8; lat_max = 8;
    start_frame(0, 0);
    for (int k = 0; k < 20 && n_acc < 3; k++) step();
    check("inflight_before_reset", 64'(pend_q.size()), 64'(3));
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    ref_q.delete();
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      step();
      check("late_rvalid_dropped", 64'({bus.pix_valid, bus.mem_req, bus.busy}), 64'(0));
    end
    check("late_reads_delivered", 64'(pend_q.size()), 64'(0));
    ready_mode = 2; lat_min = 2; lat_max = 2;
    start_frame(790, 595);
    finish_frame(2000, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/bg_fetch_ctrl.md
# bg_fetch_ctrl

Frame-level fetch sequencer for the background layer. On each frame start it latches the image anchor and walks the 640×480 background image row by row. For every image pixel that lands on-screen it issues one SDRAM read, then returns the RGB data in order, tagged with its screen coordinate. It sits between the SDRAM read port and the background pixel path, and owns read scheduling, clipping and backpressure for that layer.

## Interface
- SCREEN_WIDTH, 800, visible columns
- SCREEN_HEIGHT, 600, visible rows
- IMAGE_WIDTH, 640, image columns
- IMAGE_HEIGHT, 480, image rows
- DEPTH, 4, max reads in flight plus buffered pixels (power of 2)
- ADDR_W, 19, SDRAM word-address width
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  one-cycle pulse, start of frame
- anchor_x  in  10  screen column of image pixel (0,0)
- anchor_y  in  10  screen row of image pixel (0,0)
- mem_req  out  1  read request
- mem_addr  out  ADDR_W  word address = row*IMAGE_WIDTH + col
- mem_ack  in  1  request accepted when mem_req & mem_ack
- mem_rvalid  in  1  read data valid, in request order, cannot be stalled
- mem_rdata  in  24  {R,G,B}
- pix_valid, pix_ready  out/in  1  output handshake
- r_out, g_out, b_out  out  8 each  pixel colour
- x_out, y_out  out  10  screen column/row of pixel
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle pulse at end of frame

## Operation
- FSM: IDLE → SETUP → ISSUE → DRAIN → DONE → IDLE.
- IDLE: frame_start moves the FSM to SETUP. frame_start in any other state is ignored.
- SETUP: latch the anchor and clear col/row to 0. If anchor_x ≥ SCREEN_WIDTH or anchor_y ≥ SCREEN_HEIGHT, go to DONE with no requests; otherwise go to ISSUE.
- ISSUE: mem_req=1 whenever tokens < DEPTH. Address and tag for the current (col,row) are held stable while the request is unaccepted.
  - On accept: allocate a buffer entry tagged with (anchor_x+col, anchor_y+row) and advance col.
  - Clipping: if the next col reaches IMAGE_WIDTH, or anchor_x+col reaches SCREEN_WIDTH, set col=0 and row+1 in that same cycle.
  - If the next row reaches IMAGE_HEIGHT, or anchor_y+row reaches SCREEN_HEIGHT, go to DRAIN.
- DRAIN: no requests. When tokens == 0, go to DONE.
- DONE: frame_done=1 for one cycle, then IDLE.
- busy=1 in every state except IDLE.
- Tokens: +1 on mem accept, −1 on pix_valid&pix_ready. Both in the same cycle leave the count unchanged. Range is 0..DEPTH; the count never exceeds DEPTH.
- mem_rvalid fills the oldest unfilled entry. If mem_rvalid arrives with no unfilled entry, it is dropped and state is unchanged.
- Output: pix_valid=1 when the head entry is filled. Outputs stay stable while pix_valid & !pix_ready.
- Coordinate sums use 11-bit arithmetic for compares. Address computation is row*IMAGE_WIDTH+col, computed incrementally (row base += IMAGE_WIDTH per row).

## Timing
- Reset values: mem_req=0, mem_addr=0, pix_valid=0, r/g/b_out=0, x/y_out=0, busy=0, frame_done=0. FSM goes to IDLE and tokens and buffer pointers are cleared.
- Reset mid-frame aborts immediately. Read data returned after reset release is dropped (no unfilled entry).
- All outputs are registered.
- frame_start at cycle 0 → SETUP at cycle 1 → first mem_req at cycle 2.
- With mem_ack tied to 1: one request per cycle, including the cycle of a row wrap.
- mem_rvalid at cycle t → pix_valid at t+1 at the earliest, if the entry is at head.
- Last pixel handshake at cycle t → DRAIN exits at t+1 → frame_done at t+2.
- Invalid anchor: frame_done at cycle 2 after frame_start.

## Structure
- Shared package bg_pkg holds the screen/image dimension constants, the FSM state enum (IDLE, SETUP, ISSUE, DRAIN, DONE), and the pixel tag struct {x[9:0], y[9:0], rgb[23:0]}.
- Sub-module bg_pix_buf: a DEPTH-entry in-order buffer.
  - Pointers: alloc, fill, head; per-entry filled bit.
  - Ports: alloc (tag in), fill (rgb in), pop (tag+rgb out).
- The top level holds the FSM, scan counters, address generation and token counter.

## Test plan
- Anchor (0,0), mem_ack=1, rvalid 3 cycles after accept, pix_ready=1 → 307200 pixels.
  - First pixel: addr 0, (0,0). Last pixel: addr 307199, (639,479).
  - Exactly one frame_done; busy low afterwards.
- Anchor (700,550) → 5000 pixels.
  - Addrs 0..99, then 640..739, and so on. Last pixel: addr 31459, (799,599).
  - No mem_req issued for clipped columns.
- Anchor (800,0) → no mem_req; frame_done exactly 2 cycles after frame_start.
- pix_ready=0 with mem_ack=1 → exactly 4 accepts, then mem_req=0 and outputs stable. Releasing pix_ready resumes in order with no loss or duplication.
- Random mem_ack/rvalid delays plus random pix_ready → output sequence matches the reference scan order and coordinates. frame_start pulses while busy are ignored.
- rst low mid-frame with 3 reads in flight → all outputs go to their reset values. Late rvalid is ignored; a new frame_start produces a clean frame from addr 0.
